// File: rtl/issue_control_pkg.sv
// Shared CPU definitions for the issue stage: register-index width,
// multiply/divide latency defaults and the HI/LO timer state encoding.
package issue_control_pkg;

    localparam int REG_IDX_W        = 5;
    localparam int NUM_REGS         = 32;
    localparam int MULT_LAT_DEFAULT = 4;
    localparam int DIV_LAT_DEFAULT  = 32;

    typedef enum logic {
        HILO_IDLE = 1'b0,
        HILO_BUSY = 1'b1
    } hilo_state_e;

    // Counter width sized for the longer latency; kept at least one bit wide.
    function automatic int hilo_cnt_width(input int mult_lat, input int div_lat);
        int max_lat;
        max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
        return (max_lat > 1) ? $clog2(max_lat) : 1;
    endfunction

endpackage

// File: rtl/issue_control_hilo_timer.sv
// HI/LO occupancy timer: IDLE/BUSY FSM with a down-counter loaded at
// MULT/DIV issue, so busy covers exactly LAT cycles after the issue cycle.
module hilo_timer
    import issue_control_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    localparam int CNT_W = hilo_cnt_width(MULT_LAT, DIV_LAT);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

    hilo_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HILO_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HILO_IDLE: begin
                if (start_div) begin
                    state_d = HILO_BUSY;
                    cnt_d   = DIV_LOAD;
                end else if (start_mult) begin
                    state_d = HILO_BUSY;
                    cnt_d   = MULT_LOAD;
                end
            end
            HILO_BUSY: begin
                // The zero-count cycle is still busy; leave IDLE only after it.
                if (cnt_q == '0) begin
                    state_d = HILO_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = HILO_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == HILO_BUSY);

endmodule

// File: rtl/issue_control.sv
// Issue stage interlock: register scoreboard for RAW hazards plus the
// HI/LO busy check; stalls decode until every source operand is ready.
module issue_control
    import issue_control_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dec_valid,
    input  logic [REG_IDX_W-1:0] dec_rs,
    input  logic [REG_IDX_W-1:0] dec_rt,
    input  logic                 dec_rs_used,
    input  logic                 dec_rt_used,
    input  logic [REG_IDX_W-1:0] dec_dest,
    input  logic                 dec_dest_we,
    input  logic                 dec_mult,
    input  logic                 dec_div,
    input  logic                 dec_hilo_rd,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic                 flush,
    output logic                 issue,
    output logic                 enable_decode,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 hilo_busy
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                rs_hazard, rt_hazard, hilo_hazard, hazard;
    logic                set_en;

    // Hazards look only at registered state, so a same-cycle writeback
    // still stalls its consumer for this cycle.
    assign rs_hazard   = dec_rs_used && (dec_rs != '0) && pending_q[dec_rs];
    assign rt_hazard   = dec_rt_used && (dec_rt != '0) && pending_q[dec_rt];
    assign hilo_hazard = (dec_hilo_rd || dec_mult || dec_div) && hilo_busy;
    assign hazard      = dec_valid && (rs_hazard || rt_hazard || hilo_hazard);

    assign issue         = dec_valid && !hazard && !flush;
    assign enable_decode = !hazard;
    assign set_en        = issue && dec_dest_we && (dec_dest != '0);

    // Per-register next state: flush beats set, set beats writeback clear.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                assign pending_d[gi] =
                    flush                                                ? 1'b0 :
                    (set_en && (dec_dest == REG_IDX_W'(gi)))            ? 1'b1 :
                    (wb_valid && (wb_dest == REG_IDX_W'(gi)))           ? 1'b0 :
                    pending_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    hilo_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_hilo_timer (
        .clock      (clock),
        .reset      (reset),
        .start_mult (issue && dec_mult),
        .start_div  (issue && dec_div),
        .busy       (hilo_busy)
    );

endmodule

// File: tb/tb_issue_control.sv
// Directed bench for issue_control: a vector table for scoreboard behaviour
// plus hand-written sequences for the multi-cycle HI/LO and reset cases.
module tb_issue_control;

    logic        clock;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs, dec_rt;
    logic        dec_rs_used, dec_rt_used;
    logic [4:0]  dec_dest;
    logic        dec_dest_we;
    logic        dec_mult, dec_div, dec_hilo_rd;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        flush;
    logic        issue, enable_decode, hilo_busy;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;

    issue_control dut (
        .clock         (clock),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_rs        (dec_rs),
        .dec_rt        (dec_rt),
        .dec_rs_used   (dec_rs_used),
        .dec_rt_used   (dec_rt_used),
        .dec_dest      (dec_dest),
        .dec_dest_we   (dec_dest_we),
        .dec_mult      (dec_mult),
        .dec_div       (dec_div),
        .dec_hilo_rd   (dec_hilo_rd),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .flush         (flush),
        .issue         (issue),
        .enable_decode (enable_decode),
        .pending       (pending),
        .hilo_busy     (hilo_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [4:0]  rs;
        logic        rsu;
        logic [4:0]  rt;
        logic        rtu;
        logic [4:0]  dest;
        logic        we;
        logic        mul;
        logic        dv;
        logic        hrd;
        logic        wbv;
        logic [4:0]  wbd;
        logic        fl;
        logic        exp_issue;
        logic        exp_en;
        logic [31:0] exp_pend;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic [4:0] dest, input logic we,
                       input logic mul, input logic dv, input logic hrd,
                       input logic wbv, input logic [4:0] wbd, input logic fl,
                       input logic ei, input logic ee, input logic [31:0] ep,
                       input logic eb);
        vec_t t;
        t = '{v, rs, rsu, rt, rtu, dest, we, mul, dv, hrd, wbv, wbd, fl, ei, ee, ep, eb};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        dec_valid   = t.v;
        dec_rs      = t.rs;
        dec_rs_used = t.rsu;
        dec_rt      = t.rt;
        dec_rt_used = t.rtu;
        dec_dest    = t.dest;
        dec_dest_we = t.we;
        dec_mult    = t.mul;
        dec_div     = t.dv;
        dec_hilo_rd = t.hrd;
        wb_valid    = t.wbv;
        wb_dest     = t.wbd;
        flush       = t.fl;
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs = 0; dec_rs_used = 0; dec_rt = 0; dec_rt_used = 0;
        dec_dest = 0; dec_dest_we = 0; dec_mult = 0; dec_div = 0; dec_hilo_rd = 0;
        wb_valid = 0; wb_dest = 0; flush = 0;
    endtask

    initial begin
        int busy_cnt;
        bit done;

        //   v rs rsu rt rtu dst we mu dv hr wbv wbd fl | iss en pend        busy
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 32'h0000_0000, 0); // idle
        add(1, 1, 1, 2, 1,  5, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0020, 0); // ADD r5
        add(1, 5, 1, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0000_0020, 0); // RAW stall
        add(1, 5, 1, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0000_0020, 0);
        add(1, 5, 1, 0, 0,  6, 1, 0, 0, 0, 1, 5, 0,   0, 0, 32'h0000_0000, 0); // wb: no bypass
        add(1, 5, 1, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0040, 0); // issues next
        add(1, 0, 0, 6, 1,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 32'h0000_0040, 0); // rt hazard
        add(1, 3, 1, 6, 0,  0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0040, 0); // rt unused
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 6, 0,   0, 1, 32'h0000_0000, 0); // wb r6
        add(1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0000, 0); // dest r0
        add(1, 0, 1, 0, 1,  3, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0008, 0); // rs=r0 no stall
        add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 9, 0,   0, 1, 32'h0000_0008, 0); // wb non-pending
        add(1, 0, 0, 0, 0,  7, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0088, 0);
        add(1, 0, 0, 0, 0,  7, 1, 0, 0, 0, 1, 7, 0,   1, 1, 32'h0000_0088, 0); // set beats clear
        add(1, 0, 0, 0, 0,  4, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0098, 0);
        add(1, 0, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_00B8, 0);
        add(1, 0, 0, 0, 0,  6, 1, 0, 0, 0, 1, 3, 0,   1, 1, 32'h0000_00F0, 0);
        add(1, 0, 0, 0, 0,  9, 1, 0, 0, 0, 0, 0, 1,   0, 1, 32'h0000_0000, 0); // flush
        add(1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0004, 0);
        add(1, 2, 1, 0, 0,  3, 1, 0, 0, 0, 0, 0, 1,   0, 0, 32'h0000_0000, 0); // flush + hazard
        add(1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0,   1, 1, 32'h0000_0000, 1); // MULT
        add(1, 0, 0, 0, 0,  8, 1, 0, 0, 1, 0, 0, 0,   0, 0, 32'h0000_0000, 1); // MFHI stall
        add(1, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 32'h0000_0000, 1); // DIV stall
        add(1, 0, 0, 0, 0,  8, 1, 0, 0, 1, 0, 0, 0,   0, 0, 32'h0000_0000, 1);
        add(1, 0, 0, 0, 0,  8, 1, 0, 0, 1, 0, 0, 0,   0, 0, 32'h0000_0000, 0); // last busy
        add(1, 0, 0, 0, 0,  8, 1, 0, 0, 1, 0, 0, 0,   1, 1, 32'h0000_0100, 0); // MFHI issues

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_pending", pending, 32'h0);
        chk("reset_hilo_busy", {31'b0, hilo_busy}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_issue", i), {31'b0, issue}, {31'b0, vecs[i].exp_issue});
            chk($sformatf("v%0d_enable", i), {31'b0, enable_decode}, {31'b0, vecs[i].exp_en});
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_pending", i), pending, vecs[i].exp_pend);
            chk($sformatf("v%0d_busy", i), {31'b0, hilo_busy}, {31'b0, vecs[i].exp_busy});
            $display("vec %0d: issue=%0b en=%0b pending=%h busy=%0b", i, vecs[i].exp_issue,
                     vecs[i].exp_en, pending, hilo_busy);
        end

        // DIV followed by a waiting MFLO.
        @(negedge clock);
        idle();
        dec_valid = 1; dec_div = 1;
        #1;
        chk("div_issue", {31'b0, issue}, 32'h1);
        @(posedge clock);
        @(negedge clock);
        idle();
        dec_valid = 1; dec_hilo_rd = 1; dec_dest = 2; dec_dest_we = 1;
        busy_cnt = 0;
        done = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (hilo_busy) begin
                busy_cnt++;
                chk("mflo_stall", {31'b0, issue}, 32'h0);
            end else begin
                chk("mflo_issue", {31'b0, issue}, 32'h1);
                done = 1;
            end
            @(posedge clock);
            if (done) break;
            @(negedge clock);
        end
        chk("div_done", {31'b0, done}, 32'h1);
        chk("div_busy_cycles", busy_cnt, 32);
        #1;
        chk("mflo_dest_pending", {31'b0, pending[2]}, 32'h1);
        $display("div: busy cycles=%0d mflo issued=%0b", busy_cnt, done);

        // Reset in the tenth busy cycle of a divide.
        @(negedge clock);
        idle();
        dec_valid = 1; dec_div = 1;
        #1;
        chk("div2_issue", {31'b0, issue}, 32'h1);
        @(posedge clock);
        for (int k = 1; k < 10; k++) begin
            @(negedge clock);
            idle();
            @(posedge clock);
        end
        @(negedge clock);
        #1;
        chk("div2_busy_c10", {31'b0, hilo_busy}, 32'h1);
        reset = 1; flush = 1; wb_valid = 1; wb_dest = 2;
        dec_valid = 1; dec_dest = 11; dec_dest_we = 1;
        @(posedge clock);
        #1;
        chk("rst_mid_div_busy", {31'b0, hilo_busy}, 32'h0);
        chk("rst_mid_div_pending", pending, 32'h0);
        @(negedge clock);
        reset = 0;
        idle();
        dec_valid = 1; dec_mult = 1;
        #1;
        chk("mult_after_rst_issue", {31'b0, issue}, 32'h1);
        @(posedge clock);
        #1;
        chk("mult_busy_c1", {31'b0, hilo_busy}, 32'h1);
        @(negedge clock);
        idle();
        for (int i = 2; i <= 5; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("mult_busy_c%0d", i), {31'b0, hilo_busy}, (i <= 4) ? 32'h1 : 32'h0);
        end
        $display("reset mid-divide: pending=%h busy=%0b", pending, hilo_busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_control.md
ISSUE_CONTROL -- requirements
Module: issue_control

Interface
REQ-001 Parameter MULT_LAT, default 4, cycles HI/LO busy after MULT/MULTU issue.
REQ-002 Parameter DIV_LAT, default 32, cycles HI/LO busy after DIV/DIVU issue.
REQ-003 clock  in  1  sole clock; all state updates on posedge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 dec_valid  in  1  decode holds an instruction requesting issue.
REQ-006 dec_rs, dec_rt  in  5 each  source register indices.
REQ-007 dec_rs_used, dec_rt_used  in  1 each  source actually read.
REQ-008 dec_dest  in  5  destination register index.
REQ-009 dec_dest_we  in  1  instruction writes dec_dest.
REQ-010 dec_mult, dec_div  in  1 each  instruction is MULT/MULTU, DIV/DIVU (mutually exclusive).
REQ-011 dec_hilo_rd  in  1  instruction is MFHI/MFLO.
REQ-012 wb_valid  in  1  writeback retiring a register write this cycle.
REQ-013 wb_dest  in  5  register written by writeback.
REQ-014 flush  in  1  discard all in-flight register writes (branch/jump redirect).
REQ-015 issue  out  1  instruction accepted this cycle (combinational).
REQ-016 enable_decode  out  1  registered-stage advance enable to decode (= not stall).
REQ-017 pending  out  32  scoreboard, bit n set = write to register n outstanding.
REQ-018 hilo_busy  out  1  multiply/divide unit occupied.

Function
REQ-019 Hazard SHALL be asserted when dec_valid and any of: (dec_rs_used, dec_rs!=0, pending[dec_rs]); (dec_rt_used, dec_rt!=0, pending[dec_rt]); (dec_hilo_rd and hilo_busy); ((dec_mult or dec_div) and hilo_busy).
REQ-020 issue SHALL equal dec_valid and not hazard and not flush; enable_decode SHALL equal not (dec_valid and hazard).
REQ-021 No same-cycle bypass: a source whose pending bit clears via wb_valid this cycle SHALL still stall this cycle; issue follows next cycle.
REQ-022 On issue with dec_dest_we and dec_dest!=0, pending[dec_dest] SHALL set next cycle; register 0 SHALL never be marked pending.
REQ-023 On wb_valid, pending[wb_dest] SHALL clear next cycle; wb_valid to a non-pending register SHALL be a no-op.
REQ-024 Simultaneous issue-set and wb-clear of the same register: set SHALL win.
REQ-025 flush SHALL clear all pending bits next cycle, override any same-cycle set, and block issue that cycle; flush SHALL NOT affect the HI/LO unit.
REQ-026 HI/LO FSM states IDLE, BUSY: IDLE->BUSY on issue with dec_mult (counter loaded MULT_LAT-1) or dec_div (counter loaded DIV_LAT-1); BUSY decrements each cycle; BUSY->IDLE when counter is 0.
REQ-027 hilo_busy SHALL be 1 exactly in state BUSY, i.e. for MULT_LAT (DIV_LAT) cycles starting the cycle after issue.
REQ-028 Counter width SHALL be $clog2(max(MULT_LAT,DIV_LAT)) bits; no wrap, counter never decrements below 0.
REQ-029 dec_valid=0 SHALL produce issue=0, enable_decode=1, no state change except wb/flush/counter.

Reset
REQ-030 reset SHALL clear pending to 0, FSM to IDLE, counter to 0; hilo_busy=0 the cycle after reset.
REQ-031 reset SHALL take priority over flush, wb_valid and issue in the same cycle, including mid-divide.

Structure
REQ-032 FSM state encoding, MULT_LAT/DIV_LAT defaults and 5-bit register-index width SHALL reside in the shared CPU package.
REQ-033 One sub-module, hilo_timer (FSM plus counter), SHALL be instantiated; scoreboard logic stays in issue_control.

Verification
REQ-034 Issue ADD dest=5, next cycle ADD rs=5 -> stall (enable_decode=0) until wb_valid wb_dest=5; issue occurs the cycle after wb.
REQ-035 Issue with dec_dest=0, dec_dest_we=1 -> pending stays 0; dependent rs=0 instruction issues without stall.
REQ-036 Same cycle: issue dest=7 and wb_valid wb_dest=7 with pending[7]=1 -> pending[7]=1 afterwards.
REQ-037 Issue DIV, then MFLO -> hilo_busy high exactly 32 cycles, MFLO issues in the cycle hilo_busy first reads 0.
REQ-038 pending=0x0000_00F0, flush with a dest=9 issue request -> issue=0, pending=0 next cycle.
REQ-039 reset asserted at cycle 10 of DIV -> hilo_busy=0, pending=0 next cycle; new MULT issues immediately and busies 4 cycles.
